// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped
//   Direct-mapped, write-back, write-allocate byte cache in front of a
//   4-byte-block data memory. 8 blocks x 4 bytes, with a valid bit, a dirty bit
//   and a tag per block.
//
// Ports
//   clock          system clock, all state changes on posedge
//   reset          synchronous active-high reset
//   read, write    CPU load / store request (both high = store)
//   address        CPU byte address {tag, index, offset}
//   writedata      CPU store byte
//   readdata       CPU load byte (0 unless a read hit is presented)
//   busywait       CPU stall, high until the request can complete
//   mem_read       block read request to data memory
//   mem_write      block write request to data memory
//   mem_address    block address {tag, index}
//   mem_writedata  block being written back, byte 0 in [7:0]
//   mem_readdata   block returned by memory, byte 0 in [7:0]
//   mem_busywait   memory busy
//
// state     | meaning
// IDLE      | serve hits; launch a refill on a miss
// WRITEBACK | dirty victim block being written to memory
// FETCH     | requested block being read from memory
// UPDATE    | install fetched block, tag, valid=1, dirty=0
module dcache_direct_mapped #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int TAG_BITS   = 8 - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t state;

  logic [31:0]           data_mem [NUM_BLOCKS];
  logic [TAG_BITS-1:0]   tag_mem  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;

  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_index;
  logic [OFFSET_BITS-1:0] addr_offset;
  logic [OFFSET_BITS+2:0] byte_lsb;

  logic request;
  logic hit;
  logic idle_hit;

  assign addr_tag    = address[7 -: TAG_BITS];
  assign addr_index  = address[OFFSET_BITS +: INDEX_BITS];
  assign addr_offset = address[OFFSET_BITS-1:0];
  assign byte_lsb    = {addr_offset, 3'b000};

  assign request  = read | write;
  assign hit      = valid[addr_index] && (tag_mem[addr_index] == addr_tag);
  assign idle_hit = (state == IDLE) && hit;

  // A request stalls from its first cycle until it hits while the FSM is idle.
  assign busywait = request && !idle_hit;

  // read together with write is a store, so it never returns load data.
  assign readdata = (read && !write && idle_hit) ? data_mem[addr_index][byte_lsb +: 8] : 8'h00;

  // Writeback targets the victim's own tag; otherwise the CPU's block address.
  assign mem_address   = (state == WRITEBACK) ? {tag_mem[addr_index], addr_index}
                                              : address[7:OFFSET_BITS];
  assign mem_writedata = data_mem[addr_index];

  // mem_read/mem_write are flops loaded alongside the state, so they track
  // FETCH/WRITEBACK exactly and are never high together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            if (hit) begin
              if (write) begin
                data_mem[addr_index][byte_lsb +: 8] <= writedata;
                dirty[addr_index]                   <= 1'b1;
              end
            end else if (valid[addr_index] && dirty[addr_index]) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
            end else begin
              state    <= FETCH;
              mem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state     <= FETCH;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          data_mem[addr_index] <= mem_readdata;
          tag_mem[addr_index]  <= addr_tag;
          valid[addr_index]    <= 1'b1;
          dirty[addr_index]    <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
module tb_dcache_direct_mapped;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dcache_direct_mapped dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  // Block memory: busy for mem_lat cycles after a request, finishes on the
  // first posedge where busywait is low.
  logic [31:0] mem_array [64];
  int mem_cnt = 0;
  int mem_lat = 1;
  bit mem_load = 1'b0;

  always @(posedge clock) begin
    if (mem_load)
      for (int i = 0; i < 64; i++) mem_array[6'(i)] <= $urandom;
    if (reset || !(mem_read || mem_write)) mem_cnt <= 0;
    else if (mem_cnt == mem_lat) begin
      if (mem_write) mem_array[mem_address] <= mem_writedata;
      mem_cnt <= 0;
    end else mem_cnt <= mem_cnt + 1;
  end

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt != mem_lat);
  assign mem_readdata = mem_array[mem_address];

  // Reference model: CPU-visible bytes, memory-visible bytes, cache directory.
  logic [7:0] ref_bytes [256];
  logic [7:0] ref_mem   [256];
  bit         ref_valid [8];
  bit         ref_dirty [8];
  logic [2:0] ref_tag   [8];

  task automatic model_load_from_memory();
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 4; b++) begin
        ref_mem[8'(w*4+b)]   = mem_array[6'(w)][b*8 +: 8];
        ref_bytes[8'(w*4+b)] = mem_array[6'(w)][b*8 +: 8];
      end
    for (int i = 0; i < 8; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; end
  endtask

  // Reset drops the cache contents: unwritten dirty data is lost.
  task automatic model_reset();
    for (int a = 0; a < 256; a++) ref_bytes[8'(a)] = ref_mem[8'(a)];
    for (int i = 0; i < 8; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; end
  endtask

  bit         exp_miss, exp_wb;
  logic [5:0] exp_wa;
  logic [31:0] exp_wd;
  logic [7:0] exp_rd;
  int         exp_cyc;

  task automatic model_access(input logic [7:0] a, input bit is_wr, input logic [7:0] wd);
    logic [2:0] idx, tg;
    logic [7:0] vbase;
    idx = a[4:2];
    tg  = a[7:5];
    exp_miss = !(ref_valid[idx] && ref_tag[idx] == tg);
    exp_wb   = exp_miss && ref_valid[idx] && ref_dirty[idx];
    vbase    = {ref_tag[idx], idx, 2'b00};
    exp_wa   = vbase[7:2];
    exp_wd   = {ref_bytes[vbase+8'd3], ref_bytes[vbase+8'd2], ref_bytes[vbase+8'd1], ref_bytes[vbase]};
    if (exp_wb)
      for (int k = 0; k < 4; k++) ref_mem[vbase+8'(k)] = ref_bytes[vbase+8'(k)];
    if (exp_miss) begin
      ref_valid[idx] = 1; ref_tag[idx] = tg; ref_dirty[idx] = 0;
    end
    if (is_wr) begin
      ref_bytes[a] = wd; ref_dirty[idx] = 1;
    end
    exp_rd  = ref_bytes[a];
    exp_cyc = exp_miss ? ((exp_wb ? mem_lat + 1 : 0) + mem_lat + 3) : 0;
  endtask

  // Observations of one CPU access.
  int         obs_cyc;
  logic [7:0] obs_rd;
  bit         obs_wb, obs_f, ovl_seen = 0;
  logic [5:0] obs_wa, obs_fa;
  logic [31:0] obs_wd;

  task automatic cpu_access(input bit rd_i, input bit wr_i, input logic [7:0] a, input logic [7:0] wd);
    @(negedge clock);
    read = rd_i; write = wr_i; address = a; writedata = wd;
    obs_cyc = 0; obs_rd = 8'h00; obs_wb = 0; obs_f = 0;
    obs_wa = '0; obs_fa = '0; obs_wd = '0;
    while (1) begin
      #1;
      if (mem_read && mem_write) ovl_seen = 1;
      if (mem_write && !obs_wb) begin obs_wb = 1; obs_wa = mem_address; obs_wd = mem_writedata; end
      if (mem_read && !obs_f) begin obs_f = 1; obs_fa = mem_address; end
      if (!busywait) begin obs_rd = readdata; break; end
      obs_cyc++;
      if (obs_cyc > 100) break;
      @(negedge clock);
    end
    @(negedge clock);
    read = 0; write = 0;
  endtask

  task automatic run(input bit rd_i, input bit wr_i, input logic [7:0] a, input logic [7:0] wd);
    model_access(a, wr_i, wd);
    cpu_access(rd_i, wr_i, a, wd);
  endtask

  task automatic test_reset();
    reset = 1; mem_load = 1; mem_lat = 1;
    @(negedge clock);
    mem_load = 0;
    @(negedge clock); #1;
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || readdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_during: got bw=%b mr=%b mw=%b rd=%h, expected 0 0 0 00", busywait, mem_read, mem_write, readdata);
    end
    reset = 0;
    @(negedge clock); #1;
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || readdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_after: got bw=%b mr=%b mw=%b rd=%h, expected 0 0 0 00", busywait, mem_read, mem_write, readdata);
    end
    model_load_from_memory();
  endtask

  task automatic test_read_miss();
    mem_lat = 2;
    run(1, 0, 8'h00, 8'h00);
    checks++;
    if (obs_cyc != exp_cyc) begin errors++; $display("FAIL read_miss_cycles: got %0d expected %0d", obs_cyc, exp_cyc); end
    checks++;
    if (!obs_f || obs_fa !== 6'h00) begin errors++; $display("FAIL read_miss_fetch: got seen=%0b addr=%h expected 1 00", obs_f, obs_fa); end
    checks++;
    if (obs_wb) begin errors++; $display("FAIL read_miss_nowb: got mem_write seen=1 expected 0"); end
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL read_miss_data: got %h expected %h", obs_rd, exp_rd); end
  endtask

  task automatic test_read_hit();
    run(1, 0, 8'h03, 8'h00);
    checks++;
    if (obs_cyc != 0 || obs_f) begin errors++; $display("FAIL read_hit_stall: got cycles=%0d fetch=%0b expected 0 0", obs_cyc, obs_f); end
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL read_hit_data: got %h expected %h", obs_rd, exp_rd); end
  endtask

  task automatic test_write_hit();
    run(0, 1, 8'h01, 8'hAB);
    checks++;
    if (obs_cyc != 0 || obs_f || obs_wb) begin
      errors++; $display("FAIL write_hit_stall: got cycles=%0d fetch=%0b wb=%0b expected 0 0 0", obs_cyc, obs_f, obs_wb);
    end
    run(1, 0, 8'h01, 8'h00);
    checks++;
    if (obs_cyc != 0 || obs_rd !== 8'hAB) begin errors++; $display("FAIL write_hit_readback: got cycles=%0d data=%h expected 0 ab", obs_cyc, obs_rd); end
  endtask

  task automatic test_dirty_eviction();
    logic [31:0] w;
    mem_lat = 2;
    run(0, 1, 8'h20, 8'h5C);
    checks++;
    if (!obs_wb || obs_wa !== 6'h00 || obs_wd[15:8] !== 8'hAB) begin
      errors++; $display("FAIL evict_wb: got seen=%0b addr=%h byte1=%h expected 1 00 ab", obs_wb, obs_wa, obs_wd[15:8]);
    end
    checks++;
    if (obs_wd !== exp_wd) begin errors++; $display("FAIL evict_wb_block: got %h expected %h", obs_wd, exp_wd); end
    checks++;
    if (!obs_f || obs_fa !== 6'h08) begin errors++; $display("FAIL evict_fetch: got seen=%0b addr=%h expected 1 08", obs_f, obs_fa); end
    checks++;
    if (obs_cyc != exp_cyc) begin errors++; $display("FAIL evict_cycles: got %0d expected %0d", obs_cyc, exp_cyc); end
    run(1, 0, 8'h20, 8'h00);
    checks++;
    if (obs_cyc != 0 || obs_rd !== 8'h5C) begin errors++; $display("FAIL evict_readback: got cycles=%0d data=%h expected 0 5c", obs_cyc, obs_rd); end
    w = mem_array[0];
    checks++;
    if (w[15:8] !== 8'hAB) begin errors++; $display("FAIL evict_memory: got byte1=%h expected ab", w[15:8]); end
  endtask

  task automatic test_simultaneous();
    mem_lat = 1;
    run(1, 1, 8'h05, 8'h77);
    checks++;
    if (obs_cyc != exp_cyc || obs_wb) begin errors++; $display("FAIL rw_both_cycles: got %0d wb=%0b expected %0d 0", obs_cyc, obs_wb, exp_cyc); end
    run(1, 0, 8'h05, 8'h00);
    checks++;
    if (obs_cyc != 0 || obs_rd !== 8'h77) begin errors++; $display("FAIL rw_both_readback: got cycles=%0d data=%h expected 0 77", obs_cyc, obs_rd); end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    mem_lat = 3;
    seen = 0;
    @(negedge clock);
    read = 1; write = 0; address = 8'h48;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_read) begin seen = 1; break; end
      @(negedge clock);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midfetch_enter: got mem_read never seen expected FETCH"); end
    reset = 1;
    @(negedge clock); #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || busywait !== 1'b1) begin
      errors++; $display("FAIL midfetch_abort: got mr=%b mw=%b bw=%b expected 0 0 1", mem_read, mem_write, busywait);
    end
    reset = 0; read = 0;
    @(negedge clock); #1;
    checks++;
    if (mem_read !== 1'b0 || busywait !== 1'b0) begin errors++; $display("FAIL midfetch_idle: got mr=%b bw=%b expected 0 0", mem_read, busywait); end
    model_reset();
    mem_lat = 1;
    run(1, 0, 8'h48, 8'h00);
    checks++;
    if (obs_cyc != exp_cyc || obs_cyc == 0 || obs_rd !== exp_rd) begin
      errors++; $display("FAIL midfetch_reissue: got cycles=%0d data=%h expected %0d %h", obs_cyc, obs_rd, exp_cyc, exp_rd);
    end
    run(1, 0, 8'h20, 8'h00);
    checks++;
    if (obs_cyc != exp_cyc || obs_wb || obs_rd !== exp_rd) begin
      errors++; $display("FAIL midfetch_lost_dirty: got cycles=%0d wb=%0b data=%h expected %0d 0 %h", obs_cyc, obs_wb, obs_rd, exp_cyc, exp_rd);
    end
    run(1, 0, 8'h01, 8'h00);
    checks++;
    if (obs_cyc != exp_cyc || obs_rd !== 8'hAB) begin
      errors++; $display("FAIL midfetch_written_back: got cycles=%0d data=%h expected %0d ab", obs_cyc, obs_rd, exp_cyc);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    int op;
    for (int n = 0; n < 120; n++) begin
      a  = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      mem_lat = $urandom_range(1, 3);
      run(op != 1, op != 0, a, 8'($urandom));
      checks++;
      if (obs_cyc != exp_cyc) begin errors++; $display("FAIL rand_cycles[%0d] addr=%h: got %0d expected %0d", n, a, obs_cyc, exp_cyc); end
      checks++;
      if (obs_wb != exp_wb) begin errors++; $display("FAIL rand_wb_seen[%0d] addr=%h: got %0b expected %0b", n, a, obs_wb, exp_wb); end
      if (exp_wb) begin
        checks++;
        if (obs_wa !== exp_wa || obs_wd !== exp_wd) begin
          errors++; $display("FAIL rand_wb[%0d]: got %h/%h expected %h/%h", n, obs_wa, obs_wd, exp_wa, exp_wd);
        end
      end
      checks++;
      if (obs_f != exp_miss || (exp_miss && obs_fa !== a[7:2])) begin
        errors++; $display("FAIL rand_fetch[%0d]: got seen=%0b addr=%h expected %0b %h", n, obs_f, obs_fa, exp_miss, a[7:2]);
      end
      if (op == 0) begin
        checks++;
        if (obs_rd !== exp_rd) begin errors++; $display("FAIL rand_read[%0d] addr=%h: got %h expected %h", n, a, obs_rd, exp_rd); end
      end
    end
  endtask

  task automatic test_memory_image();
    int bad;
    logic [31:0] w;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      w = mem_array[6'(i)];
      for (int b = 0; b < 4; b++)
        if (w[b*8 +: 8] !== ref_mem[8'(i*4+b)]) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL memory_image: got %0d differing bytes expected 0", bad); end
    checks++;
    if (ovl_seen) begin errors++; $display("FAIL mem_exclusive: got mem_read&mem_write=1 expected never"); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_eviction();
    test_simultaneous();
    test_reset_mid_fetch();
    test_random();
    test_memory_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
